seq_match_ctrl: RTL
===================

SEQ_MATCH_CTRL -- requirements
Module: seq_match_ctrl

Interface
REQ-001 Parameter PATTERN, default 4'b1011, target bit sequence; the first-received bit is PATTERN[PAT_LEN-1].
REQ-002 Parameter PAT_LEN, default 4, pattern length in bits, range 2..8.
REQ-003 Parameter CNT_W, default 8, match counter width.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  in_data holds a byte to scan.
REQ-007 in_ready  out  1  controller accepts a byte this cycle.
REQ-008 in_data  in  8  byte to serialize.
REQ-009 cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every bit cycle.
REQ-010 thresh  in  CNT_W  match-count threshold; 0 disables thresh_hit.
REQ-011 clr  in  1  synchronous clear of engine state, counter and thresh_hit.
REQ-012 busy  out  1  a byte is being shifted.
REQ-013 match_pulse  out  1  one-cycle pulse on a completed match (registered).
REQ-014 match_cnt  out  CNT_W  saturating match count.
REQ-015 thresh_hit  out  1  sticky flag; set when match_cnt reaches thresh.

Function
REQ-016 The controller FSM SHALL have two states: IDLE and SHIFT, with a 3-bit bit index.
REQ-017 A byte SHALL be accepted on in_valid && in_ready; in_ready SHALL be 1 in IDLE, and in SHIFT when bit index = 7 (last bit).
REQ-018 On accept, the FSM SHALL enter (or stay in) SHIFT with bit index 0, and latch in_data.
REQ-019 In SHIFT, one bit per cycle SHALL go to the engine, MSB first: bit 7 at index 0 through bit 0 at index 7; throughput SHALL be 8 cycles/byte back-to-back.
REQ-020 At index 7 without an accept, the FSM SHALL return to IDLE; busy = (state == SHIFT).
REQ-021 The engine SHALL be a Mealy detector whose state is the matched-prefix length 0..PAT_LEN-1; a mismatch SHALL fall back to the longest matching prefix (KMP-style), not to 0.
REQ-022 A match SHALL be flagged combinationally in the engine when state = PAT_LEN-1 and the bit equals the final pattern bit; match_pulse SHALL assert in the next cycle.
REQ-023 After a match, the next engine state SHALL be the longest proper border of PATTERN if cfg_overlap = 1, else 0.
REQ-024 Engine state SHALL persist across byte boundaries and idle gaps; matches may span bytes.
REQ-025 On each match, match_cnt SHALL increment, saturating at 2^CNT_W-1.
REQ-026 thresh_hit SHALL be set in the cycle match_cnt becomes equal to a nonzero thresh, and SHALL hold until clr or rst.
REQ-027 clr SHALL zero engine state, match_cnt and thresh_hit; a simultaneous match is discarded (clr wins); clr SHALL NOT abort the byte in flight.

Reset
REQ-028 rst SHALL force: FSM IDLE, bit index 0, engine state 0, in_ready 1, busy 0, match_pulse 0, match_cnt 0, thresh_hit 0; a byte in flight is dropped.

Configuration
REQ-029 With SEQ_LSB_FIRST_EN defined, bytes SHALL be serialized LSB first (bit 0 at index 0); without it, MSB first per REQ-019; all other behaviour is identical.

Structure
REQ-030 A shared package seq_pkg SHALL hold the FSM state typedef (IDLE, SHIFT) and the default pattern/length constants.
REQ-031 The detector SHALL be a sub-module seq_det_engine (clk, rst, clr, bit_valid, bit_in, overlap -> match); the border table is derived from PATTERN at elaboration.

Verification
REQ-032 Default params, overlap=1, byte 0xB0 -> one match_pulse 4 cycles after the SHIFT start cycle (+1 registered); match_cnt=1.
REQ-033 Byte 0xB6, overlap=1 -> 2 matches (bit indices 3 and 6); same byte after clr with overlap=0 -> 1 match.
REQ-034 Bytes 0x0A then 0xC0 back-to-back -> in_ready high at index 7; a single match at index 1 of the second byte (cross-byte).
REQ-035 CNT_W=2, thresh=3, stream of 0xBB bytes -> thresh_hit set at the third match; match_cnt saturates at 3; clr then returns both to 0.
REQ-036 Assert rst mid-byte (index 4) -> all outputs at reset values immediately; no match_pulse follows; the next accept starts at index 0.

Source files
------------

// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg -- shared types and constants for the sequence-match controller.
//
// Contents:
//   ctrl_state_e  controller FSM states (IDLE, SHIFT)
//   DEF_PATTERN   default target pattern (4'b1011, first bit received = MSB)
//   DEF_PAT_LEN   default pattern length
//   DEF_CNT_W     default match-counter width
//   dfa_next()    elaboration-time helper: next matched-prefix length of the
//                 KMP detector for a given state and input bit
// ---------------------------------------------------------------------------
package seq_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ctrl_state_e;

   localparam logic [7:0] DEF_PATTERN = 8'b0000_1011;
   localparam int         DEF_PAT_LEN = 4;
   localparam int         DEF_CNT_W   = 8;

   // Longest proper prefix of the pattern that is a suffix of
   // (prefix of length s) followed by bit b. The result never equals len, so
   // calling it with s = len-1 and b = last pattern bit yields the longest
   // proper border of the whole pattern, i.e. the overlapping restart point.
   // Pattern bit i in reception order is pat[len-1-i].
   function automatic int unsigned dfa_next(input logic [7:0]  pat,
                                            input int unsigned len,
                                            input int unsigned s,
                                            input logic        b);
      logic [8:0]  seq;
      int unsigned best;
      logic        ok;
      seq  = '0;
      best = 0;
      for (int unsigned j = 0; j < s; j++) seq[j] = pat[len-1-j];
      seq[s] = b;
      for (int unsigned k = 1; k <= s + 1; k++) begin
         if (k < len) begin
            ok = 1'b1;
            for (int unsigned i = 0; i < k; i++)
               if (pat[len-1-i] != seq[s+1-k+i]) ok = 1'b0;
            if (ok) best = k;
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/seq_match_ctrl_if.sv
// ---------------------------------------------------------------------------
// seq_match_ctrl_if -- byte stream, configuration and status bundle of the
// sequence-match controller.
//
// Signals:
//   in_valid / in_ready / in_data   byte handshake into the controller
//   cfg_overlap                     1 = overlapping detection
//   thresh                          match-count threshold (0 = disabled)
//   clr                             synchronous clear of engine/counter/flag
//   busy                            a byte is being shifted
//   match_pulse                     registered one-cycle pulse per match
//   match_cnt                       saturating match count
//   thresh_hit                      sticky threshold-reached flag
// Modports: master (stimulus side), slave (controller side).
// ---------------------------------------------------------------------------
interface seq_match_ctrl_if #(
   parameter int CNT_W = seq_pkg::DEF_CNT_W
);
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_data;
   logic             cfg_overlap;
   logic [CNT_W-1:0] thresh;
   logic             clr;
   logic             busy;
   logic             match_pulse;
   logic [CNT_W-1:0] match_cnt;
   logic             thresh_hit;

   modport master (
      output in_valid, in_data, cfg_overlap, thresh, clr,
      input  in_ready, busy, match_pulse, match_cnt, thresh_hit
   );

   modport slave (
      input  in_valid, in_data, cfg_overlap, thresh, clr,
      output in_ready, busy, match_pulse, match_cnt, thresh_hit
   );
endinterface

// File: rtl/seq_det_engine.sv
// ---------------------------------------------------------------------------
// seq_det_engine -- Mealy KMP bit-sequence detector.
//
// State is the matched-prefix length 0..PAT_LEN-1. On a mismatch the state
// falls back to the longest matching prefix; after a match it restarts at
// the pattern's longest proper border (overlap_i = 1) or at 0. The
// transition table is computed from PATTERN at elaboration.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   clr_i        synchronous clear of the matched-prefix state
//   bit_valid_i  bit_in_i is a stream bit this cycle
//   bit_in_i     stream bit
//   overlap_i    overlapping detection select
//   match_o      combinational: this bit completes the pattern
// ---------------------------------------------------------------------------
module seq_det_engine
   import seq_pkg::*;
#(
   parameter logic [7:0] PATTERN = DEF_PATTERN,
   parameter int         PAT_LEN = DEF_PAT_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic bit_valid_i,
   input  logic bit_in_i,
   input  logic overlap_i,
   output logic match_o
);

   localparam int          ST_W     = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
   localparam int unsigned BORDER   = dfa_next(PATTERN, PAT_LEN, PAT_LEN - 1, PATTERN[0]);
   localparam logic        LAST_BIT = PATTERN[0];

   logic [ST_W-1:0] nxt0 [PAT_LEN];
   logic [ST_W-1:0] nxt1 [PAT_LEN];
   logic [ST_W-1:0] state_q, state_d;

   for (genvar s = 0; s < PAT_LEN; s++) begin : g_tab
      localparam int unsigned N0 = dfa_next(PATTERN, PAT_LEN, s, 1'b0);
      localparam int unsigned N1 = dfa_next(PATTERN, PAT_LEN, s, 1'b1);
      assign nxt0[s] = ST_W'(N0);
      assign nxt1[s] = ST_W'(N1);
   end

   assign match_o = bit_valid_i && (state_q == ST_W'(PAT_LEN - 1)) && (bit_in_i == LAST_BIT);

   // NOTE: every variable written here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      if (clr_i) begin
         state_d = '0;
      end else if (bit_valid_i) begin
         if (match_o)
            state_d = overlap_i ? ST_W'(BORDER) : '0;
         else
            state_d = bit_in_i ? nxt1[state_q] : nxt0[state_q];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= '0;
      else     state_q <= state_d;
   end

endmodule

// File: rtl/seq_match_ctrl.sv
// ---------------------------------------------------------------------------
// seq_match_ctrl -- byte-to-bit serializer feeding a KMP pattern detector,
// with a saturating match counter and a sticky threshold flag.
//
// A byte is accepted on in_valid && in_ready and shifted out one bit per
// cycle for 8 cycles; in_ready is also high on the last bit so bytes can be
// streamed back-to-back. Detector state persists across bytes and idle gaps.
//
// Ports:
//   clk   clock (rising edge)
//   rst   asynchronous active-high reset; drops any byte in flight
//   bus   seq_match_ctrl_if.slave (handshake, config, status)
//
// Build option: SEQ_LSB_FIRST_EN -- serialize each byte LSB first instead of
// the default MSB first.
// ---------------------------------------------------------------------------
module seq_match_ctrl
   import seq_pkg::*;
#(
   parameter logic [7:0] PATTERN = DEF_PATTERN,
   parameter int         PAT_LEN = DEF_PAT_LEN,
   parameter int         CNT_W   = DEF_CNT_W
) (
   input  logic            clk,
   input  logic            rst,
   seq_match_ctrl_if.slave bus
);

   ctrl_state_e      state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       data_q, data_d;
   logic             accept;
   logic             bit_valid;
   logic             bit_in;
   logic             det_match;
   logic             match_pulse_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit_q, hit_d;

   // ---------------- controller FSM ----------------
   assign bus.in_ready = (state_q == IDLE) || (idx_q == 3'd7);
   assign accept       = bus.in_valid && bus.in_ready;
   assign bus.busy     = (state_q == SHIFT);
   assign bit_valid    = (state_q == SHIFT);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      if (accept) begin
         state_d = SHIFT;
         idx_d   = 3'd0;
         data_d  = bus.in_data;
      end else if (state_q == SHIFT) begin
         if (idx_q == 3'd7) begin
            state_d = IDLE;
            idx_d   = 3'd0;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end
   end

`ifdef SEQ_LSB_FIRST_EN
   assign bit_in = data_q[idx_q];
`else
   assign bit_in = data_q[3'd7 - idx_q];
`endif

   // ---------------- detector ----------------
   seq_det_engine #(
      .PATTERN (PATTERN),
      .PAT_LEN (PAT_LEN)
   ) u_engine (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (bus.clr),
      .bit_valid_i (bit_valid),
      .bit_in_i    (bit_in),
      .overlap_i   (bus.cfg_overlap),
      .match_o     (det_match)
   );

   // ---------------- counter and threshold ----------------
   // clr wins over a simultaneous match. The flag is only set by an actual
   // increment, so it marks the cycle the count becomes equal to thresh.
   always_comb begin
      cnt_d = cnt_q;
      hit_d = hit_q;
      if (bus.clr) begin
         cnt_d = '0;
         hit_d = 1'b0;
      end else if (det_match && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
         if ((cnt_d == bus.thresh) && (bus.thresh != '0)) hit_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         idx_q         <= 3'd0;
         data_q        <= 8'h00;
         match_pulse_q <= 1'b0;
         cnt_q         <= '0;
         hit_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         data_q        <= data_d;
         match_pulse_q <= det_match && !bus.clr;
         cnt_q         <= cnt_d;
         hit_q         <= hit_d;
      end
   end

   assign bus.match_pulse = match_pulse_q;
   assign bus.match_cnt   = cnt_q;
   assign bus.thresh_hit  = hit_q;

endmodule
